// File: rtl/ps2_rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ps2_rx_ctrl_pkg : state and error encodings for the PS/2 receive sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_rx_ctrl_pkg;

    localparam logic [2:0] ST_FLUSH  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_LOAD   = 3'd5;

    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_DATA) || (st == ST_PARITY) || (st == ST_STOP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_ctrl_recv.sv
// ---------------------------------------------------------------------------
// ps2_rx_ctrl_recv : PS/2 frame shift datapath, advanced one bit per enable
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx_ctrl_recv (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_sclr,
    input  logic       i_en,
    input  logic       i_dat,
    output logic [7:0] o_data
);

    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       par;

    // bit_cnt: 0 = waiting for start, 1..8 = data, 9 = parity, 10 = stop
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= 4'd0;
            shift   <= 8'd0;
            par     <= 1'b0;
            o_data  <= 8'd0;
        end else if (i_sclr) begin
            bit_cnt <= 4'd0;
            shift   <= 8'd0;
            par     <= 1'b0;
        end else if (i_en) begin
            if (bit_cnt == 4'd0) begin
                if (!i_dat) begin
                    bit_cnt <= 4'd1;
                    par     <= 1'b0;
                end
            end else if (bit_cnt <= 4'd8) begin
                shift   <= {i_dat, shift[7:1]};
                par     <= par ^ i_dat;
                bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
                bit_cnt <= (i_dat == par) ? 4'd10 : 4'd0;
            end else begin
                o_data  <= shift;
                bit_cnt <= 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_rx_ctrl : PS/2 keyboard receive sequencer with watchdog and 1-entry output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx_ctrl
    import ps2_rx_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int TW          = 17
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_err_vld,
    output logic [1:0] o_err,
    output logic       o_busy
);

    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT_CYC - 1);

    logic          clk_s1, sclk, sclk_d;
    logic          dat_s1, sdat;
    logic          fall;
    logic [2:0]    state;
    logic [2:0]    cnt;
    logic          par;
    logic          stop_bad;
    logic [TW-1:0] wd;
    logic          busy;
    logic          recv_sclr;
    logic          recv_en;
    logic [7:0]    recv_data;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_s1 <= 1'b0;
            sclk   <= 1'b0;
            sclk_d <= 1'b0;
            dat_s1 <= 1'b0;
            sdat   <= 1'b0;
        end else begin
            clk_s1 <= i_ps2_clk;
            sclk   <= clk_s1;
            sclk_d <= sclk;
            dat_s1 <= i_ps2_dat;
            sdat   <= dat_s1;
        end
    end

    assign fall = sclk_d & ~sclk;
    assign busy = is_busy(state);

    // Holding recv cleared while disabled keeps it aligned with the IDLE state here
    assign recv_sclr = (state == ST_FLUSH) | ~i_en;
    assign recv_en   = fall & (state != ST_FLUSH);

    ps2_rx_ctrl_recv u_recv (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (recv_sclr),
        .i_en    (recv_en),
        .i_dat   (sdat),
        .o_data  (recv_data)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_FLUSH;
            cnt       <= 3'd0;
            par       <= 1'b0;
            stop_bad  <= 1'b0;
            wd        <= '0;
            o_valid   <= 1'b0;
            o_data    <= 8'd0;
            o_err_vld <= 1'b0;
            o_err     <= 2'd0;
        end else begin
            o_err_vld <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (fall || !busy) begin
                wd <= '0;
            end else if (wd != '1) begin
                wd <= wd + 1'b1;
            end

            if (!i_en) begin
                state <= (state == ST_FLUSH || state == ST_IDLE) ? ST_IDLE : ST_FLUSH;
            end else if (busy && !fall && wd >= WD_LIMIT) begin
                state <= ST_FLUSH;
            end else begin
                case (state)
                    ST_FLUSH: state <= ST_IDLE;
                    ST_IDLE, ST_LOAD: begin
                        if (state == ST_LOAD && !stop_bad) begin
                            if (!o_valid || i_ready) begin
                                o_data  <= recv_data;
                                o_valid <= 1'b1;
                            end else begin
                                o_err_vld <= 1'b1;
                                o_err     <= ERR_OVERRUN;
                            end
                        end
                        if (fall && !sdat) begin
                            state <= ST_DATA;
                            cnt   <= 3'd0;
                            par   <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA: if (fall) begin
                        par <= par ^ sdat;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: if (fall) begin
                        if (sdat == par) begin
                            state <= ST_STOP;
                        end else begin
                            state     <= ST_IDLE;
                            o_err_vld <= 1'b1;
                            o_err     <= ERR_PARITY;
                        end
                    end
                    ST_STOP: if (fall) begin
                        state    <= ST_LOAD;
                        stop_bad <= ~sdat;
                        if (!sdat) begin
                            o_err_vld <= 1'b1;
                            o_err     <= ERR_FRAME;
                        end
                    end
                    default: state <= ST_FLUSH;
                endcase
            end
        end
    end

    assign o_busy = busy;

endmodule

`default_nettype wire
